// File: rtl/npc_commit_pkg.sv
// Shared types and constants for the commit/difftest register file slice.
package npc_commit_pkg;

    localparam int XLEN   = 64;
    localparam int NR_GPR = 32;
    localparam int REG_AW = 5;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // One retired instruction as seen by the difftest side.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              rd_en;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              skip;
    } commit_entry_t;

    // x0 is hardwired to zero, so a write to it is never architectural.
    function automatic logic is_reg_write(input logic rd_en, input logic [REG_AW-1:0] rd);
        return rd_en && (rd != '0);
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// In-order queue of commit events; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module commit_fifo
    import npc_commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  commit_entry_t push_entry_i,
    input  logic          pop_i,
    output commit_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    commit_entry_t mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full queue is legal only when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer next-state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; the pointers alone define which entries are valid.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/commit_regfile.sv
// Architectural register file with a live copy for decode and a difftest-view
// copy that advances only when the difftest side consumes a commit event.
module commit_regfile
    import npc_commit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic                     wb_rd_en,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]          wb_rd_data,
    input  logic                     wb_skip,
    input  logic [REG_AW-1:0]        rs1_addr,
    input  logic [REG_AW-1:0]        rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [NR_GPR*XLEN-1:0]   gpr_view,
    output logic [XLEN-1:0]          pc_view,
    output logic                     dt_valid,
    input  logic                     dt_ready,
    output logic [XLEN-1:0]          dt_pc,
    output logic                     dt_skip,
    output logic                     dt_step,
    output logic [XLEN-1:0]          commit_cnt
);

    logic [XLEN-1:0] live_q [NR_GPR];
    logic [XLEN-1:0] view_q [NR_GPR];
    logic [XLEN-1:0] pc_view_q;
    logic [XLEN-1:0] commit_cnt_q, commit_cnt_d;
    logic            dt_step_q;

    logic            fifo_full, fifo_empty;
    logic            wb_fire, dt_fire;
    commit_entry_t   push_entry, head;

    assign wb_ready   = !fifo_full || dt_ready;
    assign wb_fire    = wb_valid && wb_ready;
    assign dt_valid   = !fifo_empty;
    assign dt_fire    = dt_valid && dt_ready;
    assign push_entry = '{pc: wb_pc, rd_en: wb_rd_en, rd: wb_rd, data: wb_rd_data, skip: wb_skip};

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (wb_fire),
        .push_entry_i (push_entry),
        .pop_i        (dt_fire),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Head event is masked to zero when nothing is pending.
    assign dt_pc   = fifo_empty ? '0 : head.pc;
    assign dt_skip = fifo_empty ? 1'b0 : head.skip;

    // Live read ports with write-through bypass from the commit being accepted.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            if (wb_fire && wb_rd_en && (wb_rd == rs1_addr)) rs1_data = wb_rd_data;
            else                                           rs1_data = live_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            if (wb_fire && wb_rd_en && (wb_rd == rs2_addr)) rs2_data = wb_rd_data;
            else                                           rs2_data = live_q[rs2_addr];
        end
    end

    // Commit counter next-state; wraps naturally at 2^64.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (wb_fire) commit_cnt_d = commit_cnt_q + 64'd1;
    end

    // Live and view regfiles, view PC, commit counter and step pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR_GPR; i++) begin
                live_q[i] <= '0;
                view_q[i] <= '0;
            end
            pc_view_q    <= RESET_PC;
            commit_cnt_q <= '0;
            dt_step_q    <= 1'b0;
        end else begin
            if (wb_fire && is_reg_write(wb_rd_en, wb_rd)) live_q[wb_rd] <= wb_rd_data;
            if (dt_fire) begin
                if (is_reg_write(head.rd_en, head.rd)) view_q[head.rd] <= head.data;
                pc_view_q <= head.pc;
            end
            commit_cnt_q <= commit_cnt_d;
            dt_step_q    <= dt_fire;
        end
    end

    // Flatten the view regfile, x0 in the least significant word.
    for (genvar g = 0; g < NR_GPR; g++) begin : g_view
        assign gpr_view[g*XLEN +: XLEN] = view_q[g];
    end

    assign pc_view    = pc_view_q;
    assign commit_cnt = commit_cnt_q;
    assign dt_step    = dt_step_q;

endmodule

// File: tb/tb_commit_regfile.sv
// Self-checking bench: a queue scoreboard and register models track what the
// live copy, the difftest view and the event stream must show.
module tb_commit_regfile;
    import npc_commit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          wb_valid, wb_ready, wb_rd_en, wb_skip;
    logic [63:0]   wb_pc, wb_rd_data;
    logic [4:0]    wb_rd, rs1_addr, rs2_addr;
    logic [63:0]   rs1_data, rs2_data, pc_view, dt_pc, commit_cnt;
    logic [2047:0] gpr_view;
    logic          dt_valid, dt_ready, dt_skip, dt_step;

    always #5 clock = ~clock;

    commit_regfile #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data), .wb_skip(wb_skip),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .gpr_view(gpr_view), .pc_view(pc_view),
        .dt_valid(dt_valid), .dt_ready(dt_ready), .dt_pc(dt_pc), .dt_skip(dt_skip),
        .dt_step(dt_step), .commit_cnt(commit_cnt)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    commit_entry_t sb [$];
    logic [63:0]   m_live [32];
    logic [63:0]   m_view [32];
    logic [63:0]   m_pc_view, m_cnt;
    logic          m_step;

    // Tick outputs shared by the tests.
    logic          t_pop, t_valid, t_skip;
    logic [63:0]   t_pc;
    commit_entry_t t_head;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_live[i] = '0;
            m_view[i] = '0;
        end
        m_pc_view = RST_PC;
        m_cnt     = '0;
        m_step    = 1'b0;
        sb.delete();
    endtask

    function automatic logic [2047:0] model_view_flat();
        logic [2047:0] f;
        for (int i = 0; i < 32; i++) f[i*64 +: 64] = m_view[i];
        return f;
    endfunction

    task automatic drive_wb(input logic v, input logic [63:0] pc, input logic en,
                            input logic [4:0] rd, input logic [63:0] d, input logic sk);
        wb_valid = v; wb_pc = pc; wb_rd_en = en; wb_rd = rd; wb_rd_data = d; wb_skip = sk;
    endtask

    // Samples the head event, advances the model by one edge, then clocks.
    task automatic tick(output logic popped, output commit_entry_t exp_head,
                        output logic [63:0] obs_pc, output logic obs_skip, output logic obs_valid);
        commit_entry_t e;
        logic          ready;
        #1;
        obs_pc    = dt_pc;
        obs_skip  = dt_skip;
        obs_valid = dt_valid;
        ready     = (sb.size() < DEPTH) || dt_ready;
        popped    = (sb.size() != 0) && dt_ready;
        exp_head  = '0;
        if (popped) begin
            exp_head = sb.pop_front();
            if (exp_head.rd_en && exp_head.rd != 0) m_view[exp_head.rd] = exp_head.data;
            m_pc_view = exp_head.pc;
        end
        if (wb_valid && ready) begin
            e = '{pc: wb_pc, rd_en: wb_rd_en, rd: wb_rd, data: wb_rd_data, skip: wb_skip};
            sb.push_back(e);
            if (wb_rd_en && wb_rd != 0) m_live[wb_rd] = wb_rd_data;
            m_cnt = m_cnt + 64'd1;
        end
        m_step = popped;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        // State right after power-on reset.
        #1;
        n_checks++;
        if (gpr_view !== '0 || pc_view !== RST_PC || commit_cnt !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_init: pc_view=%h cnt=%0d view_nonzero=%0b, required pc_view=%h cnt=0 view=0",
                     pc_view, commit_cnt, |gpr_view, RST_PC);
        end
        n_checks++;
        if (dt_valid !== 1'b0 || dt_step !== 1'b0 || dt_pc !== 64'd0 || dt_skip !== 1'b0 || wb_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_dt: valid=%b step=%b pc=%h skip=%b wb_ready=%b, required 0 0 0 0 1",
                     dt_valid, dt_step, dt_pc, dt_skip, wb_ready);
        end
        // Build up some state, then pull reset in the middle of a cycle.
        dt_ready = 1'b0;
        drive_wb(1, 64'h8000_0100, 1, 5'd3, 64'h55, 0);
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        dt_ready = 1'b1;
        drive_wb(1, 64'h8000_0104, 1, 5'd4, 64'h66, 0);
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        drive_wb(0, 0, 0, 0, 0, 0);
        dt_ready = 1'b0;
        rs1_addr = 5'd3;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (gpr_view !== '0 || pc_view !== RST_PC || dt_valid !== 1'b0 || commit_cnt !== 64'd0 || rs1_data !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid: pc_view=%h valid=%b cnt=%0d rs1=%h view_nonzero=%0b, required %h 0 0 0 0",
                     pc_view, dt_valid, commit_cnt, rs1_data, |gpr_view, RST_PC);
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_single();
        dt_ready = 1'b0;
        rs1_addr = 5'd5;
        drive_wb(1, 64'h8000_0000, 1, 5'd5, 64'h1234, 0);
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        drive_wb(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rs1_data !== m_live[5] || gpr_view[5*64 +: 64] !== m_view[5]) begin
            n_errors++;
            $display("FAIL single_live: rs1=%h view_x5=%h, required %h %h",
                     rs1_data, gpr_view[5*64 +: 64], m_live[5], m_view[5]);
        end
        n_checks++;
        if (dt_valid !== 1'b1 || dt_pc !== sb[0].pc) begin
            n_errors++;
            $display("FAIL single_event: valid=%b pc=%h, required 1 %h", dt_valid, dt_pc, sb[0].pc);
        end
        dt_ready = 1'b1;
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        dt_ready = 1'b0;
        n_checks++;
        if (gpr_view[5*64 +: 64] !== 64'h1234 || pc_view !== 64'h8000_0000 || dt_step !== 1'b1) begin
            n_errors++;
            $display("FAIL single_consume: view_x5=%h pc_view=%h step=%b, required 1234 80000000 1",
                     gpr_view[5*64 +: 64], pc_view, dt_step);
        end
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        n_checks++;
        if (dt_step !== 1'b0 || dt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_pulse: step=%b valid=%b, required 0 0", dt_step, dt_valid);
        end
    endtask

    task automatic test_x0();
        dt_ready = 1'b0;
        rs1_addr = 5'd0;
        drive_wb(1, 64'h8000_0200, 1, 5'd0, 64'hFFFF, 1);
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        drive_wb(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rs1_data !== 64'd0 || dt_valid !== 1'b1 || dt_skip !== 1'b1 || commit_cnt !== m_cnt) begin
            n_errors++;
            $display("FAIL x0_write: rs1=%h valid=%b skip=%b cnt=%0d, required 0 1 1 %0d",
                     rs1_data, dt_valid, dt_skip, commit_cnt, m_cnt);
        end
        dt_ready = 1'b1;
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        dt_ready = 1'b0;
        n_checks++;
        if (gpr_view[63:0] !== 64'd0 || pc_view !== 64'h8000_0200) begin
            n_errors++;
            $display("FAIL x0_view: view_x0=%h pc_view=%h, required 0 80000200", gpr_view[63:0], pc_view);
        end
    endtask

    task automatic test_full();
        logic exp_r;
        int   guard;
        dt_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_wb(1, 64'h8000_0300 + 64'(k) * 4, 1, 5'(10 + k), 64'(100 + k), k[0]);
            tick(t_pop, t_head, t_pc, t_skip, t_valid);
        end
        drive_wb(1, 64'h8000_0310, 1, 5'd20, 64'hBEEF, 0);
        #1;
        exp_r = (sb.size() < DEPTH) || dt_ready;
        n_checks++;
        if (wb_ready !== exp_r) begin
            n_errors++;
            $display("FAIL full_stall: wb_ready=%b, required %b", wb_ready, exp_r);
        end
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        dt_ready = 1'b1;
        #1;
        n_checks++;
        if (wb_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL full_pop_accept: wb_ready=%b, required 1", wb_ready);
        end
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        n_checks++;
        if (t_pc !== t_head.pc || t_skip !== t_head.skip) begin
            n_errors++;
            $display("FAIL full_head: pc=%h skip=%b, required %h %b", t_pc, t_skip, t_head.pc, t_head.skip);
        end
        drive_wb(0, 0, 0, 0, 0, 0);
        dt_ready = 1'b0;
        #1;
        exp_r = (sb.size() < DEPTH) || dt_ready;
        n_checks++;
        if (wb_ready !== exp_r || dt_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full_occupancy: wb_ready=%b valid=%b, required %b 1", wb_ready, dt_valid, exp_r);
        end
        dt_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick(t_pop, t_head, t_pc, t_skip, t_valid);
            if (t_pop) begin
                n_checks++;
                if (t_pc !== t_head.pc) begin
                    n_errors++;
                    $display("FAIL full_drain_order: pc=%h, required %h", t_pc, t_head.pc);
                end
            end
            guard++;
        end
        n_checks++;
        if (sb.size() != 0 || gpr_view !== model_view_flat() || pc_view !== m_pc_view) begin
            n_errors++;
            $display("FAIL full_drain: left=%0d pc_view=%h, required 0 %h", sb.size(), pc_view, m_pc_view);
        end
        dt_ready = 1'b0;
    endtask

    task automatic test_bypass();
        dt_ready = 1'b1;
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        drive_wb(1, 64'h8000_0400, 1, 5'd7, 64'hAA, 0);
        #1;
        n_checks++;
        if (rs1_data !== 64'hAA || rs2_data !== 64'hAA) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: rs1=%h rs2=%h, required aa aa", rs1_data, rs2_data);
        end
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        drive_wb(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rs1_data !== m_live[7]) begin
            n_errors++;
            $display("FAIL bypass_stored: rs1=%h, required %h", rs1_data, m_live[7]);
        end
        tick(t_pop, t_head, t_pc, t_skip, t_valid);
        dt_ready = 1'b0;
    endtask

    task automatic test_stream();
        int          accepted = 0;
        int          cyc = 0;
        logic        need_new = 1'b1;
        logic        exp_fire;
        logic [63:0] exp_rs1, exp_rs2, cnt_before;
        apply_reset();
        while ((accepted < 100 || sb.size() != 0) && cyc < 3000) begin
            if (accepted < 100) begin
                if (need_new)
                    drive_wb(1, 64'h8000_1000 + 64'(accepted) * 4, ($urandom_range(0, 3) != 0),
                             5'($urandom_range(0, 31)), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
            end else begin
                drive_wb(0, 0, 0, 0, 0, 0);
            end
            dt_ready = 1'($urandom_range(0, 1));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            #1;
            exp_fire = wb_valid && ((sb.size() < DEPTH) || dt_ready);
            exp_rs1 = (rs1_addr == 0) ? 64'd0 :
                      (exp_fire && wb_rd_en && wb_rd == rs1_addr) ? wb_rd_data : m_live[rs1_addr];
            exp_rs2 = (rs2_addr == 0) ? 64'd0 :
                      (exp_fire && wb_rd_en && wb_rd == rs2_addr) ? wb_rd_data : m_live[rs2_addr];
            n_checks++;
            if (rs1_data !== exp_rs1 || rs2_data !== exp_rs2) begin
                n_errors++;
                $display("FAIL stream_live: rs1[%0d]=%h rs2[%0d]=%h, required %h %h",
                         rs1_addr, rs1_data, rs2_addr, rs2_data, exp_rs1, exp_rs2);
            end
            cnt_before = m_cnt;
            tick(t_pop, t_head, t_pc, t_skip, t_valid);
            need_new = (m_cnt != cnt_before);
            if (need_new) accepted++;
            if (t_pop) begin
                n_checks++;
                if (t_valid !== 1'b1 || t_pc !== t_head.pc || t_skip !== t_head.skip) begin
                    n_errors++;
                    $display("FAIL stream_event: valid=%b pc=%h skip=%b, required 1 %h %b",
                             t_valid, t_pc, t_skip, t_head.pc, t_head.skip);
                end
            end
            n_checks++;
            if (dt_step !== m_step) begin
                n_errors++;
                $display("FAIL stream_step: step=%b, required %b", dt_step, m_step);
            end
            if (m_step) begin
                n_checks++;
                if (gpr_view !== model_view_flat() || pc_view !== m_pc_view) begin
                    n_errors++;
                    $display("FAIL stream_view: pc_view=%h, required %h (view regs compared too)",
                             pc_view, m_pc_view);
                end
            end
            cyc++;
        end
        drive_wb(0, 0, 0, 0, 0, 0);
        dt_ready = 1'b0;
        n_checks++;
        if (cyc >= 3000) begin
            n_errors++;
            $display("FAIL stream_timeout: accepted=%0d pending=%0d, required 100 0", accepted, sb.size());
        end
        n_checks++;
        if (commit_cnt !== 64'd100 || dt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_count: cnt=%0d valid=%b, required 100 0", commit_cnt, dt_valid);
        end
    endtask

    initial begin
        reset    = 1'b0;
        dt_ready = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        drive_wb(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        test_reset();
        test_single();
        test_x0();
        test_full();
        test_bypass();
        test_stream();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/commit_regfile.md
# commit_regfile

Architectural integer register file with an in-order commit-event queue. Sits between the write-back stage and the DPI-C register-exposure block. Keeps a live copy of x0–x31 for decode reads, plus a difftest-view copy and view PC. Both copies are updated in commit order, but the view advances only when the difftest side consumes an event, so the exposed register state always matches the event being checked.

## Interface
Parameters:
- DEPTH, 4, commit-queue entries (power of two, ≥2)
- RESET_PC, 64'h8000_0000, reset value of view PC

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- wb_valid  in  1  write-back offers one retiring instruction
- wb_ready  out  1  block accepts the offered commit
- wb_pc  in  64  PC of the retiring instruction
- wb_rd_en  in  1  instruction writes a register
- wb_rd  in  5  destination register index
- wb_rd_data  in  64  write data
- wb_skip  in  1  difftest should skip (MMIO/CSR side effect)
- rs1_addr, rs2_addr  in  5  decode read addresses
- rs1_data, rs2_data  out  64  live read data, combinational
- gpr_view  out  32×64 (2048 flat, x0 in bits 63:0)  difftest-view registers, to the DPI exposer
- pc_view  out  64  PC of the last consumed commit
- dt_valid  out  1  a commit event is pending
- dt_ready  in  1  difftest side consumes the head event
- dt_pc  out  64  head event PC
- dt_skip  out  1  head event skip flag
- dt_step  out  1  one-cycle pulse: the view now includes the event consumed on the previous edge
- commit_cnt  out  64  number of accepted commits

## Operation
- Accept: wb_fire = wb_valid & wb_ready. When it is high:
  - push the entry {pc, rd_en, rd, data, skip} into the queue;
  - if rd_en and rd≠0, write the live regfile;
  - increment commit_cnt, which wraps at 2^64.
- wb_ready = !full | dt_ready. When the queue is full, a simultaneous pop frees a slot in the same cycle.
- Live reads: x0 always reads 0. If wb_fire writes the same nonzero register this cycle, rs*_data returns wb_rd_data (write-through bypass).
- Consume: dt_fire = dt_valid & dt_ready. When it is high:
  - pop the head entry;
  - if rd_en and rd≠0, write the view regfile;
  - set pc_view = head pc.
- dt_step is registered dt_fire.
- dt_valid = !empty. dt_pc and dt_skip show the head entry, and are 0 when the queue is empty.
- Push and pop in the same cycle: occupancy is unchanged, and both regfiles update on that edge.
- Push into an empty queue: dt_valid rises on the following cycle. No bypass from wb to dt.
- View invariant: gpr_view and pc_view equal the architectural state after every commit older than the head entry.
- Reset mid-operation: the queue is flushed and pending events are lost. The bench must not check across a reset.

## Timing
- Reset values:
  - both regfiles 0; pc_view = RESET_PC; commit_cnt 0;
  - queue empty; dt_valid 0; dt_step 0; dt_pc/dt_skip 0;
  - wb_ready 1 while reset is deasserted.
- Live write latency 1 edge; bypass makes a read in the same cycle see the new value.
- Commit to dt_valid: 1 cycle.
- dt_fire to gpr_view/pc_view update: the same edge. dt_step is high in the next cycle.
- Throughput: 1 commit/cycle sustained when dt_ready is held high.
- Handshakes are valid/ready. The block never drops dt_valid or changes dt_pc while dt_valid & !dt_ready.

## Structure
- Package npc_commit_pkg holds:
  - XLEN = 64, NR_GPR = 32;
  - commit_entry_t packed struct {pc, rd_en, rd, data, skip};
  - default RESET_PC.
- Sub-module commit_fifo: DEPTH-entry synchronous FIFO of commit_entry_t. It has push/pop/full/empty, uses pointers with an extra wrap bit, and has an asynchronous active-low reset.
- The top level holds the two regfile arrays, bypass logic, commit_cnt and the dt_step flop.

## Test plan
- Reset: assert reset mid-stream → gpr_view all 0, pc_view=8000_0000, dt_valid=0 immediately; commit_cnt=0.
- Single commit: pc=8000_0000, x5←0x1234, dt_ready=0 → live read of x5 =0x1234 next cycle; gpr_view x5 still 0; dt_valid=1 with dt_pc=8000_0000. Raise dt_ready → x5 view=0x1234, pc_view=8000_0000, dt_step pulses 1 cycle.
- x0 write: rd=0, data=FFFF → live and view x0 stay 0; event still queued; commit_cnt increments.
- Full queue: 4 commits with dt_ready=0 → wb_ready=0 on the 5th. Assert dt_ready with the 5th offered → accepted in the same cycle; occupancy stays 4.
- Bypass: wb writes x7←0xAA while rs1_addr=7 → rs1_data=0xAA in the same cycle.
- Streaming: 100 back-to-back commits with random dt_ready → events consumed in order, view matches a reference model after every dt_step, skip flags preserved, commit_cnt=100.
